// File: rtl/move_commit_if.sv
// rtl/move_commit_if.sv - move request/response handshake between game controller and move_commit
interface move_commit_if;
  logic       clear_req;
  logic       move_valid;
  logic       move_ready;
  logic [3:0] move_x;
  logic [3:0] move_y;
  logic       done;
  logic       accepted;

  modport master (
    output clear_req, move_valid, move_x, move_y,
    input  move_ready, done, accepted
  );

  modport slave (
    input  clear_req, move_valid, move_x, move_y,
    output move_ready, done, accepted
  );
endinterface

// File: rtl/move_commit.sv
// rtl/move_commit.sv - GoBang board-write sequencer: point-empty check, stone placement, board sweep
module move_commit #(
  parameter int BOARD_SIZE = 15,
  parameter int ADDR_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  move_commit_if.slave      mv,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wdata,
  output logic              mem_we,
  input  logic [1:0]        mem_rdata,
  output logic [1:0]        player,
  output logic [7:0]        stones,
  output logic              board_full,
  output logic              busy
);

  localparam int                CELLS      = BOARD_SIZE * BOARD_SIZE;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CELLS - 1);
  localparam logic [7:0]        MAX_STONES = 8'(CELLS);
  localparam logic [4:0]        SIZE5      = 5'(BOARD_SIZE);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    READ,
    CHECK,
    WRITE,
    RESP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] sweep_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              reject_q;
  logic [ADDR_W-1:0] move_addr;
  logic              out_of_range;
  logic              occupied;

  assign move_addr    = ADDR_W'(mv.move_y) * ADDR_W'(BOARD_SIZE) + ADDR_W'(mv.move_x);
  assign out_of_range = ({1'b0, mv.move_x} >= SIZE5) || ({1'b0, mv.move_y} >= SIZE5);
  // Any non-empty code, including the illegal 11, blocks the cell.
  assign occupied     = (mem_rdata != 2'b00);
  assign board_full   = (stones == MAX_STONES);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    mem_addr      = addr_q;
    mem_wdata     = 2'b00;
    mem_we        = 1'b0;
    mv.done       = 1'b0;
    mv.accepted   = 1'b0;
    mv.move_ready = 1'b0;
    busy          = 1'b1;
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = sweep_addr;
        if (sweep_addr == LAST_ADDR) begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        busy          = 1'b0;
        mv.move_ready = ~mv.clear_req;
        if (mv.clear_req) begin
          state_n = CLEAR;
        end else if (mv.move_valid) begin
          state_n = out_of_range ? RESP : READ;
        end
      end
      READ: begin
        state_n = CHECK;
      end
      CHECK: begin
        state_n = occupied ? RESP : WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = player;
        state_n   = RESP;
      end
      RESP: begin
        mv.done     = 1'b1;
        mv.accepted = ~reject_q;
        state_n     = IDLE;
      end
      default: begin
        state_n = CLEAR;
      end
    endcase
    // Reset masks the outputs in the same cycle so an in-flight write never lands.
    if (reset) begin
      state_n       = CLEAR;
      mem_addr      = '0;
      mem_wdata     = 2'b00;
      mem_we        = 1'b0;
      mv.done       = 1'b0;
      mv.accepted   = 1'b0;
      mv.move_ready = 1'b0;
      busy          = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sweep_addr <= '0;
      addr_q     <= '0;
      reject_q   <= 1'b0;
      player     <= 2'b01;
      stones     <= 8'd0;
    end else begin
      case (state)
        CLEAR: begin
          sweep_addr <= (sweep_addr == LAST_ADDR) ? '0 : sweep_addr + 1'b1;
        end
        IDLE: begin
          if (mv.clear_req) begin
            sweep_addr <= '0;
            player     <= 2'b01;
            stones     <= 8'd0;
          end else if (mv.move_valid) begin
            addr_q   <= move_addr;
            reject_q <= out_of_range;
          end
        end
        CHECK: begin
          if (occupied) begin
            reject_q <= 1'b1;
          end
        end
        WRITE: begin
          player <= (player == 2'b01) ? 2'b10 : 2'b01;
          if (stones != MAX_STONES) begin
            stones <= stones + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_commit.sv
// tb/tb_move_commit.sv - scoreboard bench for move_commit with a behavioural board RAM
module tb_move_commit;

  localparam int BS    = 15;
  localparam int CELLS = BS * BS;

  typedef struct {
    logic       acc;
    int         cyc;
    logic       wr;
    logic [7:0] addr;
    logic [1:0] wdata;
    logic [1:0] player;
    logic [7:0] stones;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_addr;
  logic [1:0] mem_wdata;
  logic       mem_we;
  logic [1:0] mem_rdata;
  logic [1:0] player;
  logic [7:0] stones;
  logic       board_full;
  logic       busy;

  move_commit_if mv();

  move_commit #(.BOARD_SIZE(BS), .ADDR_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .mv         (mv),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .player     (player),
    .stones     (stones),
    .board_full (board_full),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  logic [1:0] ram [0:255];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  logic [1:0] mboard [0:CELLS-1];
  logic [1:0] mplayer;
  logic [7:0] mstones;
  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) mboard[i] = 2'b00;
    mplayer = 2'b01;
    mstones = 8'd0;
  endtask

  task automatic model_move(input int x, input int y, output exp_t e);
    int a;
    e.wr = 1'b0; e.wdata = 2'b00; e.addr = 8'd0; e.acc = 1'b0;
    if (x >= BS || y >= BS) begin
      e.cyc = 1;
    end else begin
      a = y * BS + x;
      e.addr = a[7:0];
      if (mboard[a] != 2'b00) begin
        e.cyc = 3;
      end else begin
        e.acc = 1'b1; e.cyc = 4; e.wr = 1'b1; e.wdata = mplayer;
        mboard[a] = mplayer;
        mplayer = (mplayer == 2'b01) ? 2'b10 : 2'b01;
        if (mstones < 8'(CELLS)) mstones = mstones + 8'd1;
      end
    end
    e.player = mplayer;
    e.stones = mstones;
  endtask

  // Handshake one move in IDLE, follow it to done, and score against the model.
  task automatic do_move(input int x, input int y);
    exp_t e, got;
    int   c, writes;
    bit   seen;
    model_move(x, y, e);
    sb.push_back(e);
    mv.move_valid = 1'b1; mv.move_x = 4'(x); mv.move_y = 4'(y);
    #1;
    vectors++;
    if (mv.move_ready !== 1'b1) begin
      miscompares++; $display("FAIL move_ready (%0d,%0d): got %b want 1", x, y, mv.move_ready);
    end
    step();
    mv.move_valid = 1'b0; mv.move_x = 4'($urandom); mv.move_y = 4'($urandom);
    #1;
    c = 1; writes = 0; seen = 0;
    while (!seen && c <= 8) begin
      if (c == 1 && e.cyc != 1) begin
        vectors++;
        if (mem_addr !== e.addr || mem_we !== 1'b0) begin
          miscompares++; $display("FAIL read_addr (%0d,%0d): got addr %0d we %b want addr %0d we 0", x, y, mem_addr, mem_we, e.addr);
        end
      end
      if (mem_we === 1'b1) begin
        writes++;
        vectors++;
        if (c != 3 || mem_addr !== e.addr || mem_wdata !== e.wdata) begin
          miscompares++; $display("FAIL write (%0d,%0d): got cyc %0d addr %0d data %b want cyc 3 addr %0d data %b", x, y, c, mem_addr, mem_wdata, e.addr, e.wdata);
        end
      end
      if (mv.done === 1'b1) begin
        seen = 1;
        got = sb.pop_front();
        vectors++;
        if (mv.accepted !== got.acc || c != got.cyc || player !== got.player || stones !== got.stones) begin
          miscompares++; $display("FAIL resp (%0d,%0d): got acc %b cyc %0d player %b stones %0d want acc %b cyc %0d player %b stones %0d",
                                  x, y, mv.accepted, c, player, stones, got.acc, got.cyc, got.player, got.stones);
        end
      end else begin
        step();
        c++;
      end
    end
    if (!seen) begin
      void'(sb.pop_front());
      vectors++; miscompares++;
      $display("FAIL done_timeout (%0d,%0d): got no done within 8 cycles want done at cycle %0d", x, y, e.cyc);
    end
    vectors++;
    if (writes != (e.wr ? 1 : 0)) begin
      miscompares++; $display("FAIL write_count (%0d,%0d): got %0d want %0d", x, y, writes, e.wr ? 1 : 0);
    end
    step();
  endtask

  // Called with the first CLEAR cycle already on the outputs.
  task automatic wait_sweep(input string tag);
    int n = 0;
    int bad = -1;
    while (busy === 1'b1 && n < 300) begin
      if (bad < 0 && (mem_we !== 1'b1 || mem_wdata !== 2'b00 || mem_addr !== n[7:0] || mv.done !== 1'b0)) bad = n;
      step();
      n++;
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++; $display("FAIL %s sweep_seq: got bad cycle %0d want we=1 wdata=00 addr=cycle no done", tag, bad);
    end
    vectors++;
    if (n != CELLS) begin
      miscompares++; $display("FAIL %s sweep_len: got %0d want %0d", tag, n, CELLS);
    end
    vectors++;
    if (player !== 2'b01 || stones !== 8'd0 || board_full !== 1'b0) begin
      miscompares++; $display("FAIL %s post_clear: got player %b stones %0d full %b want 01 0 0", tag, player, stones, board_full);
    end
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 2'b00 || busy !== 1'b1 || mv.move_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_mem: got we %b addr %0d wdata %b busy %b ready %b want 0 0 00 1 0", mem_we, mem_addr, mem_wdata, busy, mv.move_ready);
    end
    vectors++;
    if (mv.done !== 1'b0 || mv.accepted !== 1'b0 || player !== 2'b01 || stones !== 8'd0 || board_full !== 1'b0) begin
      miscompares++; $display("FAIL reset_status: got done %b acc %b player %b stones %0d full %b want 0 0 01 0 0", mv.done, mv.accepted, player, stones, board_full);
    end
    reset = 1'b0;
    #1;
    wait_sweep("reset");
  endtask

  task automatic test_accept();
    do_move(3, 4);
    vectors++;
    if (ram[63] !== 2'b01) begin
      miscompares++; $display("FAIL ram_63: got %b want 01", ram[63]);
    end
  endtask

  task automatic test_occupied();
    do_move(3, 4);
  endtask

  task automatic test_out_of_range();
    do_move(15, 0);
    do_move(0, 15);
    do_move(15, 15);
  endtask

  task automatic test_fill();
    for (int y = 0; y < BS; y++)
      for (int x = 0; x < BS; x++)
        do_move(x, y);
    do_move(7, 7);
    vectors++;
    if (stones !== 8'(CELLS) || board_full !== 1'b1) begin
      miscompares++; $display("FAIL full: got stones %0d full %b want %0d 1", stones, board_full, CELLS);
    end
  endtask

  task automatic test_clear();
    mv.clear_req = 1'b1;
    #1;
    vectors++;
    if (mv.move_ready !== 1'b0) begin
      miscompares++; $display("FAIL clear_ready: got %b want 0", mv.move_ready);
    end
    step();
    mv.clear_req = 1'b0;
    #1;
    wait_sweep("clear");
  endtask

  task automatic test_illegal_code();
    ram[0] = 2'b11;
    mboard[0] = 2'b11;
    do_move(0, 0);
    ram[0] = 2'b00;
    mboard[0] = 2'b00;
    do_move(0, 0);
  endtask

  task automatic test_clear_with_move();
    mv.clear_req = 1'b1; mv.move_valid = 1'b1; mv.move_x = 4'd1; mv.move_y = 4'd1;
    #1;
    vectors++;
    if (mv.move_ready !== 1'b0) begin
      miscompares++; $display("FAIL clear_move_ready: got %b want 0", mv.move_ready);
    end
    step();
    mv.clear_req = 1'b0; mv.move_valid = 1'b0;
    #1;
    wait_sweep("clear_move");
  endtask

  task automatic test_reset_mid();
    mv.move_valid = 1'b1; mv.move_x = 4'd5; mv.move_y = 4'd5;
    #1;
    step();
    mv.move_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || mv.done !== 1'b0) begin
      miscompares++; $display("FAIL reset_write: got we %b done %b want 0 0", mem_we, mv.done);
    end
    step();
    vectors++;
    if (ram[80] !== 2'b00) begin
      miscompares++; $display("FAIL reset_ram80: got %b want 00", ram[80]);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    wait_sweep("reset_mid");
    do_move(5, 5);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 2'b11;
    mv.clear_req = 1'b0; mv.move_valid = 1'b0; mv.move_x = 4'd0; mv.move_y = 4'd0;
    model_clear();
    test_reset();
    test_accept();
    test_occupied();
    test_out_of_range();
    test_fill();
    test_clear();
    test_illegal_code();
    test_clear_with_move();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
